// File: rtl/ov7670_sccb_init.sv
// OV7670 register-initialisation sequencer.
// Walks a table of {register, value} entries in an external synchronous ROM.
// Each ordinary entry becomes a 3-byte SCCB write (slave address, register,
// value) through a byte-level I2C/SCCB master. The block also provides the
// power-up settle time, table-embedded delays, NACK retry and done/err status.
module ov7670_sccb_init #(
    parameter logic [7:0] SLAVE_ADDR   = 8'h42,
    parameter int         ROM_AW       = 8,
    parameter int         BOOT_CYCLES  = 2_500_000,
    parameter int         DELAY_CYCLES = 250_000,
    parameter int         GAP_CYCLES   = 256,
    parameter int         MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic [3:0]        i2c_state,
    input  logic [1:0]        i2c_ack,
    output logic              start,
    output logic              stop,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // The shared counter only ever has to reach (longest wait - 1).
    localparam int CNT_MAX = (BOOT_CYCLES > DELAY_CYCLES)
                           ? ((BOOT_CYCLES > GAP_CYCLES) ? BOOT_CYCLES : GAP_CYCLES)
                           : ((DELAY_CYCLES > GAP_CYCLES) ? DELAY_CYCLES : GAP_CYCLES);
    localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [15:0] ENTRY_END   = 16'hFFFF;
    localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;
    localparam logic [3:0]  I2C_IDLE    = 4'd0;
    localparam logic [3:0]  I2C_ACKWAIT = 4'd3;

    typedef enum logic [3:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_XFER,
        S_POST,
        S_POST_NACK,
        S_DELAY,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [7:0]      reg_byte;
    logic [7:0]      val_byte;
    logic [RW-1:0]   retry;
    logic [1:0]      ack_cnt;

    logic master_idle;
    logic ack_tick;
    logic gap_done;

    // The master holds ack[1] high while idle, so a tick only counts in its
    // ACK-wait state.
    assign master_idle = (i2c_state == I2C_IDLE);
    assign ack_tick    = (i2c_state == I2C_ACKWAIT) && i2c_ack[1];
    assign gap_done    = master_idle && (cnt == CW'(GAP_CYCLES - 1));

    // NOTE: start and stop are continuous assignments so the master sees them
    // in the very cycle it samples them; a registered copy would be one late.
    assign start = (state == S_ISSUE) && master_idle;
    assign stop  = (state == S_XFER) && ack_tick && ((ack_cnt == 2'd2) || !i2c_ack[0]);
    assign busy  = (state != S_DONE);
    assign done  = (state == S_DONE);

    // Sequencer: table walk, byte handshake, waits, retry and status.
    // NOTE: every register here uses <= so all flops update together at the
    // edge; mixing in = would make results depend on statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_BOOT;
            cnt      <= '0;
            rom_addr <= '0;
            reg_byte <= '0;
            val_byte <= '0;
            retry    <= '0;
            ack_cnt  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    if (cnt == CW'(BOOT_CYCLES - 1)) begin
                        cnt      <= '0;
                        rom_addr <= '0;
                        state    <= S_FETCH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // ROM output settles during this cycle.
                S_FETCH: begin
                    cnt   <= '0;
                    state <= S_DECODE;
                end

                S_DECODE: begin
                    cnt <= '0;
                    if (rom_data == ENTRY_END) begin
                        state <= S_DONE;
                    end else if (rom_data == ENTRY_DELAY) begin
                        state <= S_DELAY;
                    end else begin
                        reg_byte <= rom_data[15:8];
                        val_byte <= rom_data[7:0];
                        retry    <= '0;
                        wr_data  <= SLAVE_ADDR;
                        state    <= S_ISSUE;
                    end
                end

                // start is high in the idle cycle; the master latches the
                // address now, so the register byte can be presented next.
                S_ISSUE: begin
                    if (master_idle) begin
                        wr_data <= reg_byte;
                        ack_cnt <= '0;
                        state   <= S_XFER;
                    end
                end

                S_XFER: begin
                    if (ack_tick) begin
                        if (!i2c_ack[0]) begin
                            cnt   <= '0;
                            state <= S_POST_NACK;
                        end else if (ack_cnt == 2'd2) begin
                            cnt   <= '0;
                            state <= S_POST;
                        end else begin
                            if (ack_cnt == 2'd0) begin
                                wr_data <= val_byte;
                            end
                            ack_cnt <= ack_cnt + 2'd1;
                        end
                    end
                end

                // The gap is measured from the master returning to idle.
                S_POST: begin
                    if (!master_idle) begin
                        cnt <= '0;
                    end else if (gap_done) begin
                        cnt      <= '0;
                        rom_addr <= rom_addr + ROM_AW'(1);
                        state    <= S_FETCH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_POST_NACK: begin
                    if (!master_idle) begin
                        cnt <= '0;
                    end else if (gap_done) begin
                        cnt <= '0;
                        if (retry < RW'(MAX_RETRY)) begin
                            retry   <= retry + RW'(1);
                            wr_data <= SLAVE_ADDR;
                            state   <= S_ISSUE;
                        end else begin
                            err      <= 1'b1;
                            rom_addr <= rom_addr + ROM_AW'(1);
                            state    <= S_FETCH;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DELAY: begin
                    if (cnt == CW'(DELAY_CYCLES - 1)) begin
                        cnt      <= '0;
                        rom_addr <= rom_addr + ROM_AW'(1);
                        state    <= S_FETCH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Restart skips the power-up settle time.
                S_DONE: begin
                    if (go) begin
                        err      <= 1'b0;
                        rom_addr <= '0;
                        cnt      <= '0;
                        state    <= S_FETCH;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_init.sv
// Directed bench for ov7670_sccb_init with a small behavioural SCCB master.
`timescale 1ns/1ps
module tb_ov7670_sccb_init;

    localparam int BOOT     = 10;
    localparam int DELAY    = 50;
    localparam int GAP      = 4;
    localparam int RETRY    = 3;
    localparam int AW       = 4;
    localparam int BIT_LEN  = 3;
    localparam int STOP_LEN = 3;

    localparam logic [3:0] M_IDLE = 4'd0;
    localparam logic [3:0] M_BIT  = 4'd1;
    localparam logic [3:0] M_ACK  = 4'd3;
    localparam logic [3:0] M_STOP = 4'd4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go  = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [3:0]    i2c_state;
    logic [1:0]    i2c_ack;
    logic          start;
    logic          stop;
    logic [7:0]    wr_data;
    logic          busy;
    logic          done;
    logic          err;

    ov7670_sccb_init #(
        .SLAVE_ADDR  (8'h42),
        .ROM_AW      (AW),
        .BOOT_CYCLES (BOOT),
        .DELAY_CYCLES(DELAY),
        .GAP_CYCLES  (GAP),
        .MAX_RETRY   (RETRY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .i2c_state(i2c_state),
        .i2c_ack  (i2c_ack),
        .start    (start),
        .stop     (stop),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #20 clk = ~clk;

    // Synchronous table ROM.
    logic [15:0] rom [16];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Behavioural master: idle -> BIT_LEN bit cycles -> one ACK tick per
    // byte -> STOP_LEN stop cycles on stop or NACK.
    logic [3:0] m_state;
    int         m_cnt;
    int         xfer_n;
    int         byte_idx;
    int         ack_mode = 0;  // 0 always ACK, 1 NACK reg byte of 1st xfer, 2 NACK addr of xfers 1..4
    logic       ack_bit;

    always_comb begin
        ack_bit = 1'b1;
        if (ack_mode == 1 && xfer_n == 1 && byte_idx == 1) ack_bit = 1'b0;
        if (ack_mode == 2 && xfer_n <= 4 && byte_idx == 0) ack_bit = 1'b0;
    end

    assign i2c_state = m_state;
    assign i2c_ack   = (m_state == M_IDLE) ? 2'b10 :
                       (m_state == M_ACK)  ? {1'b1, ack_bit} : 2'b00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state  <= M_IDLE;
            m_cnt    <= 0;
            xfer_n   <= 0;
            byte_idx <= 0;
        end else begin
            case (m_state)
                M_IDLE: if (start) begin
                    m_state  <= M_BIT;
                    m_cnt    <= 0;
                    xfer_n   <= xfer_n + 1;
                    byte_idx <= 0;
                end
                M_BIT: if (m_cnt == BIT_LEN - 1) m_state <= M_ACK;
                       else m_cnt <= m_cnt + 1;
                M_ACK: begin
                    m_cnt <= 0;
                    if (stop || !ack_bit) begin
                        m_state <= M_STOP;
                    end else begin
                        m_state  <= M_BIT;
                        byte_idx <= byte_idx + 1;
                    end
                end
                M_STOP: if (m_cnt == STOP_LEN - 1) m_state <= M_IDLE;
                        else m_cnt <= m_cnt + 1;
                default: m_state <= M_IDLE;
            endcase
        end
    end

    // Bench bookkeeping, all written from the stimulus process only.
    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          bad_stop = 0;
    int          wide_start = 0;
    logic        prev_start = 1'b0;
    logic [7:0]  cur = 8'h00;
    logic [9:0]  log_q[$];      // {stop, ack, byte} per ACK tick
    logic [9:0]  exp_q[$];
    int          start_cyc[$];
    int          stop_done_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then observe the bus.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (start) begin
            if (prev_start) wide_start++;
            start_cyc.push_back(cyc);
            cur = wr_data;
        end
        if (stop && !(i2c_state == M_ACK && i2c_ack[1])) bad_stop++;
        if (i2c_state == M_ACK && i2c_ack[1]) begin
            log_q.push_back({stop, i2c_ack[0], cur});
            if (!stop && i2c_ack[0]) cur = wr_data;
        end
        if (m_state == M_STOP && m_cnt == STOP_LEN - 1) stop_done_cyc.push_back(cyc);
        prev_start = start;
    endtask

    task automatic clear_logs();
        log_q.delete();
        exp_q.delete();
        start_cyc.delete();
        stop_done_cyc.delete();
        cyc        = 0;
        prev_start = 1'b0;
        cur        = 8'h00;
    endtask

    task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
        rom[3] = e3;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rom_addr"}, 32'(rom_addr), 0);
        check({tag, "_start"},    32'(start),    0);
        check({tag, "_stop"},     32'(stop),     0);
        check({tag, "_wr_data"},  32'(wr_data),  0);
        check({tag, "_busy"},     32'(busy),     1);
        check({tag, "_done"},     32'(done),     0);
        check({tag, "_err"},      32'(err),      0);
    endtask

    task automatic run_until_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) step();
        check({tag, "_done"}, 32'(done), 1);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_nbytes"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        // ---------------- Basic write, go ignored during BOOT ----------------
        load_rom(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        ack_mode = 0;
        hold_reset();
        check_reset_values("reset");
        release_reset();
        repeat (3) step();
        check("boot_busy", 32'(busy), 1);
        check("boot_no_start", 32'(start), 0);
        check("boot_wr_data", 32'(wr_data), 0);
        go = 1'b1;
        step();
        go = 1'b0;
        run_until_done("basic", 1000);
        check("basic_first_start_cyc", start_cyc.size() > 0 ? start_cyc[0] : -1, BOOT + 2);
        check("basic_nstarts", start_cyc.size(), 1);
        exp_q = '{{1'b0, 1'b1, 8'h42}, {1'b0, 1'b1, 8'h12}, {1'b1, 1'b1, 8'h80}};
        compare_log("basic");
        check("basic_err", 32'(err), 0);
        check("basic_busy", 32'(busy), 0);
        check("basic_rom_addr", 32'(rom_addr), 1);

        // ---------------- Delay entry ----------------
        load_rom(16'h1101, 16'hFFF0, 16'h3A04, 16'hFFFF);
        hold_reset();
        release_reset();
        run_until_done("delay", 1000);
        exp_q = '{{1'b0, 1'b1, 8'h42}, {1'b0, 1'b1, 8'h11}, {1'b1, 1'b1, 8'h01},
                  {1'b0, 1'b1, 8'h42}, {1'b0, 1'b1, 8'h3A}, {1'b1, 1'b1, 8'h04}};
        compare_log("delay");
        check("delay_nstarts", start_cyc.size(), 2);
        if (start_cyc.size() >= 2 && stop_done_cyc.size() >= 1)
            check("delay_spacing_ok", 32'((start_cyc[1] - stop_done_cyc[0]) >= DELAY + GAP), 1);
        else
            check("delay_spacing_events", 0, 1);
        check("delay_rom_addr", 32'(rom_addr), 3);

        // ---------------- Retry then success ----------------
        load_rom(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        ack_mode = 1;
        hold_reset();
        release_reset();
        run_until_done("retry", 1000);
        exp_q = '{{1'b0, 1'b1, 8'h42}, {1'b1, 1'b0, 8'h12},
                  {1'b0, 1'b1, 8'h42}, {1'b0, 1'b1, 8'h12}, {1'b1, 1'b1, 8'h80}};
        compare_log("retry");
        check("retry_nstarts", start_cyc.size(), 2);
        check("retry_err", 32'(err), 0);

        // ---------------- Retry exhausted ----------------
        load_rom(16'h1280, 16'h3A04, 16'hFFFF, 16'hFFFF);
        ack_mode = 2;
        hold_reset();
        release_reset();
        run_until_done("exhaust", 2000);
        exp_q = '{{1'b1, 1'b0, 8'h42}, {1'b1, 1'b0, 8'h42}, {1'b1, 1'b0, 8'h42},
                  {1'b1, 1'b0, 8'h42},
                  {1'b0, 1'b1, 8'h42}, {1'b0, 1'b1, 8'h3A}, {1'b1, 1'b1, 8'h04}};
        compare_log("exhaust");
        check("exhaust_nstarts", start_cyc.size(), 5);
        check("exhaust_err", 32'(err), 1);
        check("exhaust_rom_addr", 32'(rom_addr), 2);

        // ---------------- Reset mid-transfer, then go restart ----------------
        hold_reset();
        release_reset();
        for (int i = 0; i < 100 && start_cyc.size() == 0; i++) step();
        repeat (3) step();
        check("midxfer_master_busy", 32'(i2c_state == M_BIT), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midxfer_reset");
        check("midxfer_master_idle", 32'(i2c_state), 0);
        release_reset();
        run_until_done("reboot", 2000);
        check("reboot_first_start_cyc", start_cyc.size() > 0 ? start_cyc[0] : -1, BOOT + 2);
        check("reboot_err", 32'(err), 1);

        clear_logs();
        go = 1'b1;
        step();
        go = 1'b0;
        check("go_err_cleared", 32'(err), 0);
        check("go_busy", 32'(busy), 1);
        check("go_rom_addr", 32'(rom_addr), 0);
        run_until_done("restart", 1000);
        check("restart_first_start_cyc", start_cyc.size() > 0 ? start_cyc[0] : -1, 3);
        exp_q = '{{1'b0, 1'b1, 8'h42}, {1'b0, 1'b1, 8'h12}, {1'b1, 1'b1, 8'h80},
                  {1'b0, 1'b1, 8'h42}, {1'b0, 1'b1, 8'h3A}, {1'b1, 1'b1, 8'h04}};
        compare_log("restart");
        check("restart_err", 32'(err), 0);

        // ---------------- Whole-run bus rules ----------------
        check("stop_outside_tick", bad_stop, 0);
        check("start_wider_than_one", wide_start, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ov7670_sccb_init.md
# ov7670_sccb_init

Register-initialisation sequencer for the OV7670 camera. After reset it walks a table of 16-bit {register, value} entries held in an external synchronous ROM. Each entry becomes a 3-byte SCCB write (slave address, register, value), issued through the byte-level I2C/SCCB master via that master's start/stop/wr_data/ack handshake. It also handles power-up settling, table-embedded delays, NACK retry, and reports completion and error.

## Interface

Parameters:
- `SLAVE_ADDR`, 8'h42: 8-bit write address of the camera. Bit 0 must be 0.
- `ROM_AW`, 8: ROM address width. The table holds at most 2^ROM_AW entries.
- `BOOT_CYCLES`, 2_500_000: settle time after reset before the first transfer (100 ms at 25 MHz).
- `DELAY_CYCLES`, 250_000: length of the wait inserted by a delay entry (10 ms at 25 MHz).
- `GAP_CYCLES`, 256: idle time after each completed transfer, measured from the master returning to idle.
- `MAX_RETRY`, 3: number of re-attempts for an entry after a NACK.

Ports:
- `clk` in 1: system clock, 25 MHz. This is the same clock as the master.
- `rst` in 1: asynchronous, active-high reset.
- `go` in 1: one-cycle pulse. It restarts the table from entry 0, but only when the block is in DONE.
- `rom_addr` out ROM_AW: table index. Reset value 0.
- `rom_data` in 16: entry {reg[15:8], val[7:0]}. Valid one cycle after rom_addr changes.
- `i2c_state` in 4: master state code. 0 means idle; 3 means waiting for the slave ACK.
- `i2c_ack` in 2: from the master. Bit [1] is the ACK-bit tick; bit [0] is 1 for ACK, 0 for NACK.
- `start` out 1: one-cycle transfer request to the master. Reset value 0.
- `stop` out 1: stop request to the master. Combinational. Reset value 0.
- `wr_data` out 8: byte presented to the master. Registered. Reset value 0.
- `busy` out 1: high in every state except DONE. Reset value 1.
- `done` out 1: high while in DONE. Reset value 0.
- `err` out 1: sticky flag. Set when any entry exhausts its retries. Cleared by rst or go. Reset value 0.

## Operation

Special entries:
- 16'hFFFF: end of table.
- 16'hFFF0: delay for DELAY_CYCLES. No bus traffic.
- Any other value: register write.

Valid ACK tick: i2c_ack[1]=1 while i2c_state==3. The master holds ack[1]=1 continuously while idle, so ack[1] must never be used without the state qualifier.

States and transitions:
- **BOOT**: the cycle counter runs to BOOT_CYCLES-1, then the block goes to FETCH with rom_addr=0.
- **FETCH**: lasts one cycle while rom_data settles. Then DECODE.
- **DECODE**:
  - FFFF goes to DONE.
  - FFF0 goes to DELAY.
  - Any other value: latch reg and val, set retry=0, go to ISSUE.
- **ISSUE**: wait until i2c_state==0. In that cycle, assert start=1 with wr_data=SLAVE_ADDR already held. Next cycle, load wr_data=reg, clear ack_cnt, go to XFER.
- **XFER**: counts valid ACK ticks in ack_cnt (0..2).
  - Tick with ack_cnt==0 and ACK: wr_data becomes val in the next cycle.
  - stop = XFER && valid tick && (ack_cnt==2 || i2c_ack[0]==0). stop is therefore high in the tick cycle itself, which is when the master samples it.
  - Tick with ack_cnt==2 and ACK: go to POST.
  - Tick with any NACK: go to POST_NACK.
- **POST**: wait for i2c_state==0, then count GAP_CYCLES. Then rom_addr+1 and go to FETCH.
- **POST_NACK**: wait for i2c_state==0, then count GAP_CYCLES.
  - If retry<MAX_RETRY: retry+1, wr_data=SLAVE_ADDR, go to ISSUE with the same entry.
  - Otherwise: set err, rom_addr+1, go to FETCH (the entry is skipped).
- **DELAY**: count DELAY_CYCLES, then rom_addr+1 and go to FETCH.
- **DONE**: holds state. go clears err, sets rom_addr=0, and goes to FETCH, skipping BOOT.

Width rules and boundaries:
- rom_addr wraps at 2^ROM_AW. A table with no FFFF entry therefore repeats. This is allowed but is not the intended use.
- go is ignored outside DONE.
- rst mid-transfer returns the block to BOOT with all outputs at reset values. The master must be reset together with this block.
- One shared cycle counter is sized to max(BOOT_CYCLES, DELAY_CYCLES, GAP_CYCLES) and cleared on every state entry.

## Timing

- First start pulse: BOOT_CYCLES + 2 cycles after rst deasserts (FETCH, DECODE, ISSUE), provided the master is idle.
- start is exactly one cycle wide. Between start pulses, at least one full master stop sequence plus GAP_CYCLES elapses.
- Byte latching: wr_data must equal the next byte during the valid tick, because the master latches wr_data in that cycle.
  - reg is held from ISSUE+1 through the first tick.
  - val is held from the cycle after the first tick through the second tick.
- stop is never high outside a valid tick cycle.
- Per-write latency: 3 bytes of master time + GAP_CYCLES + 2 cycles.

## Test plan

- **Basic write.** ROM = {12 80, FFFF}, bench master model always ACKs, BOOT_CYCLES=10, GAP_CYCLES=4. Expect:
  - bytes 42, 12, 80 on the bus;
  - stop on the 3rd tick;
  - done=1 and err=0 afterwards.
- **Delay entry.** ROM = {11 01, FFF0, 3A 04, FFFF}, DELAY_CYCLES=50. Expect the second start to occur no sooner than 50 + GAP_CYCLES cycles after the first stop completes.
- **Retry then success.** Model NACKs the register byte on attempt 1 and ACKs after that. Expect:
  - stop on the 2nd tick of attempt 1;
  - a full re-issue of 42, 12, 80;
  - err=0.
- **Retry exhausted.** Model always NACKs the address, MAX_RETRY=3. Expect:
  - 4 attempts, each stopped at the first tick;
  - err=1 and rom_addr advanced;
  - the following entry is still written;
  - done=1.
- **Idle-ack immunity.** Hold i2c_ack=2'b10 with i2c_state=0 throughout BOOT and ISSUE. Expect ack_cnt to stay 0 and stop to stay 0.
- **Reset and restart.** Assert rst mid-XFER. Expect outputs at reset values and BOOT restarted. Then, once in DONE, pulse go. Expect err cleared and entry 0 re-sent with no BOOT wait.
